// File: rtl/l2_output_encoder.sv
// rtl/l2_output_encoder.sv - four independent single-entry L2 output channels with handshake
`ifndef L2_TAG_BITS
`define L2_TAG_BITS 20
`endif
`ifndef L2_SET_BITS
`define L2_SET_BITS 8
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE 128
`endif
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 5
`endif
`ifndef NOC_ID_WIDTH
`define NOC_ID_WIDTH 6
`endif

module l2_output_encoder #(
    parameter int TAG_W  = `L2_TAG_BITS,
    parameter int SET_W  = `L2_SET_BITS,
    parameter int LINE_W = `BITS_PER_LINE,
    parameter int MSG_W  = `MSG_TYPE_WIDTH,
    parameter int ID_W   = `NOC_ID_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send_req_out,
    input  logic                   send_rsp_out,
    input  logic                   send_rd_rsp,
    input  logic                   send_inval,
    input  logic [MSG_W-1:0]       in_coh_msg,
    input  logic [ID_W-1:0]        in_req_id,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [SET_W-1:0]       in_set,
    input  logic [LINE_W-1:0]      in_line,
    output logic                   l2_req_out_valid,
    input  logic                   l2_req_out_ready,
    output logic [MSG_W-1:0]       l2_req_out_coh_msg,
    output logic [TAG_W+SET_W-1:0] l2_req_out_addr,
    output logic [LINE_W-1:0]      l2_req_out_line,
    output logic                   l2_rsp_out_valid,
    input  logic                   l2_rsp_out_ready,
    output logic [MSG_W-1:0]       l2_rsp_out_coh_msg,
    output logic [ID_W-1:0]        l2_rsp_out_req_id,
    output logic [TAG_W+SET_W-1:0] l2_rsp_out_addr,
    output logic [LINE_W-1:0]      l2_rsp_out_line,
    output logic                   l2_rd_rsp_valid,
    input  logic                   l2_rd_rsp_ready,
    output logic [LINE_W-1:0]      l2_rd_rsp_line,
    output logic                   l2_inval_valid,
    input  logic                   l2_inval_ready,
    output logic [TAG_W+SET_W-1:0] l2_inval_addr,
    output logic                   busy_req_out,
    output logic                   busy_rsp_out,
    output logic                   busy_rd_rsp,
    output logic                   busy_inval,
    output logic                   outputs_idle,
    output logic [2:0]             pending_cnt,
    output logic                   overflow_err
);

    logic [TAG_W+SET_W-1:0] in_addr;
    logic acc_req, acc_rsp, acc_rd, acc_inv;
    logic nxt_req, nxt_rsp, nxt_rd, nxt_inv;
    logic ovf_hit;
    logic [2:0] nxt_cnt;

    assign in_addr = {in_tag, in_set};

    // A channel is busy only when its entry is full and will not drain this cycle.
    assign busy_req_out = l2_req_out_valid & ~l2_req_out_ready;
    assign busy_rsp_out = l2_rsp_out_valid & ~l2_rsp_out_ready;
    assign busy_rd_rsp  = l2_rd_rsp_valid  & ~l2_rd_rsp_ready;
    assign busy_inval   = l2_inval_valid   & ~l2_inval_ready;

    assign outputs_idle = (pending_cnt == 3'd0);

    // Accept decisions, next valid bits and the next occupancy count.
    always_comb begin
        acc_req = send_req_out & ~busy_req_out;
        acc_rsp = send_rsp_out & ~busy_rsp_out;
        acc_rd  = send_rd_rsp  & ~busy_rd_rsp;
        acc_inv = send_inval   & ~busy_inval;
        nxt_req = acc_req | busy_req_out;
        nxt_rsp = acc_rsp | busy_rsp_out;
        nxt_rd  = acc_rd  | busy_rd_rsp;
        nxt_inv = acc_inv | busy_inval;
        ovf_hit = (send_req_out & busy_req_out) | (send_rsp_out & busy_rsp_out) |
                  (send_rd_rsp & busy_rd_rsp) | (send_inval & busy_inval);
        nxt_cnt = {2'b00, nxt_req} + {2'b00, nxt_rsp} + {2'b00, nxt_rd} + {2'b00, nxt_inv};
    end

    // Entry registers: valid bits follow next-state, payloads load only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            l2_req_out_valid   <= 1'b0;
            l2_rsp_out_valid   <= 1'b0;
            l2_rd_rsp_valid    <= 1'b0;
            l2_inval_valid     <= 1'b0;
            l2_req_out_coh_msg <= '0;
            l2_req_out_addr    <= '0;
            l2_req_out_line    <= '0;
            l2_rsp_out_coh_msg <= '0;
            l2_rsp_out_req_id  <= '0;
            l2_rsp_out_addr    <= '0;
            l2_rsp_out_line    <= '0;
            l2_rd_rsp_line     <= '0;
            l2_inval_addr      <= '0;
            pending_cnt        <= 3'd0;
            overflow_err       <= 1'b0;
        end else begin
            l2_req_out_valid <= nxt_req;
            l2_rsp_out_valid <= nxt_rsp;
            l2_rd_rsp_valid  <= nxt_rd;
            l2_inval_valid   <= nxt_inv;
            pending_cnt      <= nxt_cnt;
            if (ovf_hit)
                overflow_err <= 1'b1;
            if (acc_req) begin
                l2_req_out_coh_msg <= in_coh_msg;
                l2_req_out_addr    <= in_addr;
                l2_req_out_line    <= in_line;
            end
            if (acc_rsp) begin
                l2_rsp_out_coh_msg <= in_coh_msg;
                l2_rsp_out_req_id  <= in_req_id;
                l2_rsp_out_addr    <= in_addr;
                l2_rsp_out_line    <= in_line;
            end
            if (acc_rd)
                l2_rd_rsp_line <= in_line;
            if (acc_inv)
                l2_inval_addr <= in_addr;
        end
    end

endmodule
